riscboy_ppu_pixel_unpacker: RTL and testbench
=============================================

# riscboy_ppu_pixel_unpacker

Converts packed 32-bit pixel-data words from the PPU fetch path into a stream of one pixel per cycle for the palette mapper. Each span is started by a command giving format, pixel count, start offset and palette base. Paletted formats emit a palette index with `out_paletted` high; the direct-colour format emits the 15-bit colour with `out_paletted` low. Sits between the fetch FIFO and the palette mapper input, and drives that input's valid/data/paletted signals.

## Interface
- `W_PIXDATA`, 15: output pixel width.
- `W_PALETTE_IDX`, 8: palette index width, must be ≤ `W_PIXDATA`.
- `W_COUNT`, 10: span pixel-count width.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `span_start`  in  1  start pulse; accepted only when `busy` is low.
- `span_fmt`  in  3  format: 0=1bpp, 1=2bpp, 2=4bpp, 3=8bpp (all paletted), 4=16bpp direct, 5–7 behave as 4.
- `span_count`  in  `W_COUNT`  number of pixels to emit.
- `span_shift`  in  5  index of the first pixel within the first word, masked to pixels-per-word − 1.
- `span_pal_base`  in  `W_PALETTE_IDX`  offset added to paletted indices.
- `busy`  out  1  span in progress.
- `span_done`  out  1  one-cycle pulse when a span completes.
- `in_vld`  in  1  fetch word valid.
- `in_rdy`  out  1  unpacker accepts the word.
- `in_data`  in  32  packed pixel word.
- `out_vld`  out  1  pixel valid.
- `out_rdy`  in  1  downstream accepts the pixel.
- `out_data`  out  `W_PIXDATA`  pixel: a colour, or a zero-extended palette index.
- `out_paletted`  out  1  `out_data` is a palette index.

## Operation
- A transfer happens on either interface when vld and rdy are both high at a rising edge.
- States:
  - IDLE: `busy` = 0.
  - FETCH: no word held.
  - EMIT: word held and `out_vld` = 1.
- IDLE + `span_start`:
  - Latch fmt, count, base and masked shift into the pixel index `pix`.
  - Go to FETCH, or go to DONE if count = 0.
- `span_start` while `busy` is ignored.
- FETCH: `in_rdy` = 1. On an `in_vld` transfer, latch the word and go to EMIT.
- EMIT:
  - bpp = 1 << fmt for fmt 0–3, else 16.
  - Pixels per word `ppw` = 32/bpp.
  - Raw pixel = `word[pix*bpp +: bpp]`, taken LSB-first.
  - Paletted output = `(raw + pal_base) mod 2^W_PALETTE_IDX`, zero-extended to `W_PIXDATA`.
  - Direct output = `word[pix*16 +: 15]`; bit 15 of each halfword is ignored.
  - On each output transfer, `remaining` decrements.
    - If `remaining` becomes 0, the word is discarded and the block goes to DONE.
    - Otherwise, if `pix` = `ppw`−1, `pix` is set to 0 and the word is released.
    - Otherwise `pix` increments.
- Word release for back-to-back throughput:
  - `in_rdy` = 1 in EMIT when `out_vld && out_rdy && pix == ppw-1 && remaining > 1`.
  - If `in_vld` is also high, the new word is latched in the same cycle and the block stays in EMIT.
  - Otherwise it goes to FETCH.
- DONE: lasts one cycle with `span_done` = 1, `busy` = 1 and `in_rdy` = 0, then goes to IDLE.
- `in_rdy` is 0 in IDLE and DONE, so the next span's words are never prefetched.
- Only the first word of a span honours `span_shift`; every later word starts at pix 0.
- Unused pixels in the last word are dropped, and the block never consumes more words than the span needs.

## Timing
- Reset values: `busy` = 0, `span_done` = 0, `in_rdy` = 0, `out_vld` = 0, `out_data` = 0, `out_paletted` = 0; state IDLE.
- `out_*`, `in_rdy` and `span_done` are combinational from registered state plus `out_rdy`/`in_vld`. There is no combinational path from `in_data` to `out_*`.
- Latency:
  - From `span_start`, `in_rdy` rises on the next cycle.
  - After a word transfer, the first pixel is valid on the next cycle.
- Sustained throughput is 1 pixel/cycle across word boundaries, provided `in_vld` stays high.
- `out_data` and `out_paletted` hold stable while `out_vld && !out_rdy`.
- Asserting `rst_n` mid-span aborts immediately. No `span_done` is produced and the partial word is lost.

## Test plan
- 8bpp, count=4, shift=0, base=0x10, word 0x04030201, `out_rdy`=1 → outputs 0x11, 0x12, 0x13, 0x14 on consecutive cycles, `out_paletted`=1, one word consumed, then `span_done`.
- 1bpp, count=40, words 0x0000_0005 and 0x0000_00FF, `in_vld` always high → 40 pixels with no bubble at the word boundary: 1,0,1,0,0… then 1×8, 0×… ; exactly 2 words consumed.
- 16bpp, count=3, shift=1, words 0xFFFF_1234 and 0x8001_7FFF → 0x7FFF, 0x7FFF, 0x0001, `out_paletted`=0.
- 4bpp with `out_rdy` toggling randomly → the pixel sequence matches the reference model, and data stays stable while stalled.
- count=0 → `span_done` on the next cycle with no input transfer; a `span_start` issued during DONE is ignored.
- Reset mid-span, after 2 of 8 pixels → all outputs return to reset values; a new span starts cleanly.

Source files
------------

// File: rtl/riscboy_ppu_pixel_unpacker_if.sv
// rtl/riscboy_ppu_pixel_unpacker_if.sv - span command, fetch-word and pixel stream signals of the unpacker
interface riscboy_ppu_pixel_unpacker_if #(
  parameter int W_PIXDATA     = 15,
  parameter int W_PALETTE_IDX = 8,
  parameter int W_COUNT       = 10
);
  logic                     span_start;
  logic [2:0]               span_fmt;
  logic [W_COUNT-1:0]       span_count;
  logic [4:0]               span_shift;
  logic [W_PALETTE_IDX-1:0] span_pal_base;
  logic                     busy;
  logic                     span_done;
  logic                     in_vld;
  logic                     in_rdy;
  logic [31:0]              in_data;
  logic                     out_vld;
  logic                     out_rdy;
  logic [W_PIXDATA-1:0]     out_data;
  logic                     out_paletted;

  modport master (
    output span_start, span_fmt, span_count, span_shift, span_pal_base,
    output in_vld, in_data, out_rdy,
    input  busy, span_done, in_rdy, out_vld, out_data, out_paletted
  );

  modport slave (
    input  span_start, span_fmt, span_count, span_shift, span_pal_base,
    input  in_vld, in_data, out_rdy,
    output busy, span_done, in_rdy, out_vld, out_data, out_paletted
  );
endinterface

// File: rtl/riscboy_ppu_pixel_unpacker.sv
// rtl/riscboy_ppu_pixel_unpacker.sv - unpacks 32-bit fetch words into one pixel per cycle
module riscboy_ppu_pixel_unpacker #(
  parameter int W_PIXDATA     = 15,
  parameter int W_PALETTE_IDX = 8,
  parameter int W_COUNT       = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  riscboy_ppu_pixel_unpacker_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [2:0]               fmt_q, fmt_d;
  logic [W_COUNT-1:0]       remaining_q, remaining_d;
  logic [W_PALETTE_IDX-1:0] pal_base_q, pal_base_d;
  logic [4:0]               pix_q, pix_d;
  logic [31:0]              word_q, word_d;

  // Formats 4..7 are all 16bpp direct colour.
  function automatic logic [2:0] log2_bpp(input logic [2:0] fmt);
    return fmt[2] ? 3'd4 : fmt;
  endfunction

  function automatic logic [4:0] last_pix_idx(input logic [2:0] fmt);
    return 5'd31 >> log2_bpp(fmt);
  endfunction

  logic [4:0]               bit_ofs;
  logic [14:0]              shifted;
  logic [7:0]               idx_mask;
  logic [W_PALETTE_IDX-1:0] pal_idx;
  logic                     out_xfer;
  logic                     last_pix;

  always_comb begin
    idx_mask = 8'hff;
    case (fmt_q)
      3'd0:    idx_mask = 8'h01;
      3'd1:    idx_mask = 8'h03;
      3'd2:    idx_mask = 8'h0f;
      default: idx_mask = 8'hff;
    endcase
    bit_ofs  = pix_q << log2_bpp(fmt_q);
    shifted  = 15'(word_q >> bit_ofs);
    pal_idx  = W_PALETTE_IDX'(shifted[7:0] & idx_mask) + pal_base_q;
    last_pix = (pix_q == last_pix_idx(fmt_q));
    out_xfer = (state_q == S_EMIT) && bus.out_rdy;
  end

  // Outputs are forced to zero outside EMIT so idle values match reset values.
  always_comb begin
    bus.busy         = (state_q != S_IDLE);
    bus.span_done    = (state_q == S_DONE);
    bus.out_vld      = (state_q == S_EMIT);
    bus.out_paletted = (state_q == S_EMIT) && !fmt_q[2];
    bus.out_data     = '0;
    if (state_q == S_EMIT) begin
      bus.out_data = fmt_q[2] ? W_PIXDATA'(shifted) : W_PIXDATA'(pal_idx);
    end
  end

  always_comb begin
    state_d     = state_q;
    fmt_d       = fmt_q;
    remaining_d = remaining_q;
    pal_base_d  = pal_base_q;
    pix_d       = pix_q;
    word_d      = word_q;
    bus.in_rdy  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.span_start) begin
          fmt_d       = bus.span_fmt;
          remaining_d = bus.span_count;
          pal_base_d  = bus.span_pal_base;
          pix_d       = bus.span_shift & last_pix_idx(bus.span_fmt);
          state_d     = (bus.span_count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        bus.in_rdy = 1'b1;
        if (bus.in_vld) begin
          word_d  = bus.in_data;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_xfer) begin
          remaining_d = remaining_q - W_COUNT'(1);
          if (remaining_q == W_COUNT'(1)) begin
            state_d = S_DONE;
          end else if (last_pix) begin
            // Swap in the next word on the same edge to avoid a bubble.
            pix_d      = '0;
            bus.in_rdy = 1'b1;
            if (bus.in_vld) begin
              word_d = bus.in_data;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            pix_d = pix_q + 5'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fmt_q       <= '0;
      remaining_q <= '0;
      pal_base_q  <= '0;
      pix_q       <= '0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      fmt_q       <= fmt_d;
      remaining_q <= remaining_d;
      pal_base_q  <= pal_base_d;
      pix_q       <= pix_d;
      word_q      <= word_d;
    end
  end

endmodule

// File: tb/tb_riscboy_ppu_pixel_unpacker.sv
// tb/tb_riscboy_ppu_pixel_unpacker.sv - directed self-checking bench for the pixel unpacker
module tb_riscboy_ppu_pixel_unpacker;
  localparam int W_PIXDATA     = 15;
  localparam int W_PALETTE_IDX = 8;
  localparam int W_COUNT       = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscboy_ppu_pixel_unpacker_if #(
    .W_PIXDATA(W_PIXDATA), .W_PALETTE_IDX(W_PALETTE_IDX), .W_COUNT(W_COUNT)
  ) bus ();

  riscboy_ppu_pixel_unpacker #(
    .W_PIXDATA(W_PIXDATA), .W_PALETTE_IDX(W_PALETTE_IDX), .W_COUNT(W_COUNT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] feed[$];
  logic [15:0] out_q[$];
  logic [15:0] exp_q[$];
  int          out_cyc[$];
  int          word_cyc[$];
  int          words     = 0;
  int          done_cnt  = 0;
  int          cyc       = 0;
  bit          feed_en   = 1'b1;
  bit          rdy_rand  = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_px;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives fetch words / out_rdy on the falling edge, logs transfers just before the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      bus.in_vld  = feed_en && (feed.size() != 0);
      bus.in_data = (feed.size() != 0) ? feed[0] : 32'h0;
      if (rdy_rand) bus.out_rdy = 1'($urandom_range(0, 1));
      #2;
      if (rst_n) begin
        if (prev_stall)
          check("stall_hold", {15'h0, bus.out_vld, bus.out_paletted, bus.out_data}, {15'h0, 1'b1, prev_px});
        prev_stall = bus.out_vld && !bus.out_rdy;
        prev_px    = {bus.out_paletted, bus.out_data};
        if (bus.out_vld && bus.out_rdy) begin
          out_q.push_back({bus.out_paletted, bus.out_data});
          out_cyc.push_back(cyc);
        end
        if (bus.in_vld && bus.in_rdy) begin
          void'(feed.pop_front());
          words++;
          word_cyc.push_back(cyc);
        end
        if (bus.span_done) done_cnt++;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic clear_logs();
    feed.delete(); out_q.delete(); exp_q.delete(); out_cyc.delete(); word_cyc.delete();
    words = 0;
  endtask

  task automatic start_span(input logic [2:0] f, input int cnt, input logic [4:0] sh, input logic [7:0] base);
    @(negedge clk);
    bus.span_start    = 1'b1;
    bus.span_fmt      = f;
    bus.span_count    = W_COUNT'(cnt);
    bus.span_shift    = sh;
    bus.span_pal_base = base;
    @(negedge clk);
    bus.span_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      @(negedge clk);
      #3;
    end
    check(tag, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      check(tag, {16'h0, out_q[i]}, {16'h0, exp_q[i]});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, {31'h0, bus.busy}, 32'd0);
    check({tag, "_done"}, {31'h0, bus.span_done}, 32'd0);
    check({tag, "_in_rdy"}, {31'h0, bus.in_rdy}, 32'd0);
    check({tag, "_out_vld"}, {31'h0, bus.out_vld}, 32'd0);
    check({tag, "_out_data"}, {17'h0, bus.out_data}, 32'd0);
    check({tag, "_out_pal"}, {31'h0, bus.out_paletted}, 32'd0);
  endtask

  logic [31:0] w4[4];
  int          d_before;

  initial begin
    bus.span_start = 1'b0; bus.span_fmt = 3'd0; bus.span_count = '0;
    bus.span_shift = 5'd0; bus.span_pal_base = '0;
    bus.in_vld = 1'b0; bus.in_data = 32'h0; bus.out_rdy = 1'b1;

    repeat (3) @(negedge clk);
    #1 check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 8bpp, palette base offset, single word
    clear_logs();
    feed.push_back(32'h0403_0201);
    feed.push_back(32'hdead_beef);
    start_span(3'd3, 4, 5'd0, 8'h10);
    #1 check("t1_in_rdy_latency", {31'h0, bus.in_rdy}, 32'd1);
    wait_done("t1_done", 50);
    exp_q = '{16'h8011, 16'h8012, 16'h8013, 16'h8014};
    check_stream("t1_pix");
    check("t1_words", 32'(words), 32'd1);
    if (out_cyc.size() == 4 && word_cyc.size() >= 1) begin
      check("t1_first_pix_latency", 32'(out_cyc[0] - word_cyc[0]), 32'd1);
      check("t1_back_to_back", 32'(out_cyc[3] - out_cyc[0]), 32'd3);
    end

    // 1bpp across a word boundary, no bubble
    @(negedge clk); #3;
    clear_logs();
    feed.push_back(32'h0000_0005);
    feed.push_back(32'h0000_00ff);
    feed.push_back(32'h1234_5678);
    start_span(3'd0, 40, 5'd0, 8'h00);
    wait_done("t2_done", 100);
    for (int i = 0; i < 32; i++) exp_q.push_back((i == 0 || i == 2) ? 16'h8001 : 16'h8000);
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h8001);
    check_stream("t2_pix");
    check("t2_words", 32'(words), 32'd2);
    if (out_cyc.size() == 40) check("t2_no_bubble", 32'(out_cyc[39] - out_cyc[0]), 32'd39);

    // 16bpp direct with start shift, bit 15 dropped
    @(negedge clk); #3;
    clear_logs();
    feed.push_back(32'hffff_1234);
    feed.push_back(32'h8001_7fff);
    start_span(3'd4, 3, 5'd1, 8'h55);
    wait_done("t3_done", 50);
    exp_q = '{16'h7fff, 16'h7fff, 16'h0001};
    check_stream("t3_pix");
    check("t3_words", 32'(words), 32'd2);

    // 4bpp with random backpressure against a reference model
    @(negedge clk); #3;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      w4[i] = $urandom;
      feed.push_back(w4[i]);
    end
    for (int i = 0; i < 20; i++) begin
      int p;
      logic [31:0] w;
      logic [7:0]  raw;
      p   = 3 + i;
      w   = w4[p >> 3];
      raw = 8'((w >> ((p & 7) * 4)) & 32'hf);
      exp_q.push_back({1'b1, 7'h0, raw + 8'hf0});
    end
    rdy_rand = 1'b1;
    start_span(3'd2, 20, 5'd3, 8'hf0);
    wait_done("t4_done", 400);
    rdy_rand = 1'b0;
    bus.out_rdy = 1'b1;
    check_stream("t4_pix");
    check("t4_words", 32'(words), 32'd3);

    // zero-length span, start during DONE ignored
    @(negedge clk); #3;
    clear_logs();
    feed.push_back(32'h0101_0101);
    d_before = done_cnt;
    @(negedge clk);
    bus.span_start = 1'b1; bus.span_fmt = 3'd3; bus.span_count = '0;
    bus.span_shift = 5'd0; bus.span_pal_base = 8'h00;
    @(negedge clk);
    bus.span_count = W_COUNT'(5);
    #1;
    check("t5_done_pulse", {31'h0, bus.span_done}, 32'd1);
    check("t5_busy_in_done", {31'h0, bus.busy}, 32'd1);
    check("t5_in_rdy_in_done", {31'h0, bus.in_rdy}, 32'd0);
    @(negedge clk);
    bus.span_start = 1'b0;
    #1;
    check("t5_start_ignored_busy", {31'h0, bus.busy}, 32'd0);
    check("t5_start_ignored_rdy", {31'h0, bus.in_rdy}, 32'd0);
    repeat (4) @(negedge clk);
    #3;
    check("t5_words", 32'(words), 32'd0);
    check("t5_done_count", 32'(done_cnt - d_before), 32'd1);

    // reset after 2 of 8 pixels, then a clean span
    clear_logs();
    feed.push_back(32'h0403_0201);
    feed.push_back(32'h0807_0605);
    start_span(3'd3, 8, 5'd0, 8'h00);
    for (int i = 0; i < 100 && out_q.size() < 2; i++) begin
      @(negedge clk);
      #3;
    end
    check("t6_reached_two", 32'(out_q.size()), 32'd2);
    d_before = done_cnt;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("t6_rst");
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #3 check("t6_no_done", 32'(done_cnt - d_before), 32'd0);
    feed.push_back(32'haabb_ccdd);
    start_span(3'd3, 2, 5'd0, 8'h00);
    wait_done("t6_new_done", 50);
    exp_q = '{16'h80dd, 16'h80cc};
    check_stream("t6_new_pix");
    check("t6_new_words", 32'(words), 32'd1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end
endmodule
